// File: rtl/sq_qpn_arbiter.sv
// Round-robin arbiter feeding one registered QPN to SQ context fetch; accept in cycle N, offered in N+1.
// Sources are only accepted when the holding register is empty or is being drained by qpn_ready.
module sq_qpn_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int QPN_WIDTH = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*QPN_WIDTH-1:0]  src_qpn,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic                          qpn_valid,
    output logic [QPN_WIDTH-1:0]          qpn_data,
    input  logic                          qpn_ready,
    output logic [2:0]                    grant_src,
    output logic [31:0]                   grant_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [QPN_WIDTH-1:0] r_qpn;
    logic [2:0]           r_grant_src;
    logic [2:0]           r_last_grant;
    logic [31:0]          r_grant_cnt;

    logic                 w_found;
    logic [2:0]           w_winner;
    logic [QPN_WIDTH-1:0] w_win_qpn;
    logic                 w_cap_opp;
    logic                 w_capture;
    logic [NUM_SRC-1:0]   w_src_rdy;

    // Search order starts one past the last grant; the first valid hit in that order wins.
    always_comb begin
        w_found   = 1'b0;
        w_winner  = '0;
        w_win_qpn = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!w_found && src_valid[i] &&
                    ((int'(r_last_grant) + k) % NUM_SRC == i)) begin
                    w_found   = 1'b1;
                    w_winner  = 3'(i);
                    w_win_qpn = src_qpn[i*QPN_WIDTH +: QPN_WIDTH];
                end
            end
        end
    end

    assign w_cap_opp = (r_state == IDLE) || ((r_state == HOLD) && qpn_ready);
    assign w_capture = w_cap_opp && w_found && !rst;

    always_comb begin
        w_src_rdy = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_capture && (w_winner == 3'(i))) begin
                w_src_rdy[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = w_capture ? HOLD : IDLE;
            HOLD:    w_state_nxt = (qpn_ready && !w_capture) ? IDLE : HOLD;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reset value of last_grant makes source 0 the first to be searched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_qpn        <= '0;
            r_grant_src  <= '0;
            r_last_grant <= 3'(NUM_SRC - 1);
            r_grant_cnt  <= '0;
        end else if (w_capture) begin
            r_qpn        <= w_win_qpn;
            r_grant_src  <= w_winner;
            r_last_grant <= w_winner;
            r_grant_cnt  <= r_grant_cnt + 32'd1;
        end
    end

    assign src_ready = w_src_rdy;
    assign qpn_valid = (r_state == HOLD);
    assign qpn_data  = r_qpn;
    assign grant_src = r_grant_src;
    assign grant_cnt = r_grant_cnt;

endmodule

// File: tb/tb_sq_qpn_arbiter.sv
// Directed bench for sq_qpn_arbiter: stimulus pushes expected grants, a negedge monitor checks each consumed QPN.
module tb_sq_qpn_arbiter;
    localparam int N = 4;
    localparam int W = 24;

    typedef struct packed {
        logic [W-1:0] qpn;
        logic [2:0]   src;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     src_valid;
    logic [N*W-1:0]   src_qpn;
    logic [N-1:0]     src_ready;
    logic             qpn_valid;
    logic [W-1:0]     qpn_data;
    logic             qpn_ready;
    logic [2:0]       grant_src;
    logic [31:0]      grant_cnt;

    logic [W-1:0]     qv [N];
    exp_t             sb [$];
    int               errors = 0;
    int               checks = 0;

    sq_qpn_arbiter #(.NUM_SRC(N), .QPN_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_qpn   (src_qpn),
        .src_ready (src_ready),
        .qpn_valid (qpn_valid),
        .qpn_data  (qpn_data),
        .qpn_ready (qpn_ready),
        .grant_src (grant_src),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push(input int s);
        exp_t e;
        e.qpn = qv[s];
        e.src = 3'(s);
        sb.push_back(e);
    endtask

    // Monitor: every handshake on the output side consumes one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && qpn_valid === 1'b1 && qpn_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_underflow: got qpn 0x%0h with no expected entry", qpn_data);
            end else begin
                e = sb.pop_front();
                chk("mon_qpn", 32'(qpn_data), 32'(e.qpn));
                chk("mon_src", 32'(grant_src), 32'(e.src));
            end
        end
    end

    initial begin
        qv[0] = 24'h000123;
        qv[1] = 24'hA11111;
        qv[2] = 24'hFEDCBA;
        qv[3] = 24'hABCDEF;
        for (int i = 0; i < N; i++) src_qpn[i*W +: W] = qv[i];
        rst       = 1'b1;
        src_valid = '1;
        qpn_ready = 1'b0;

        // Reset state, with requests present to confirm no accept under reset
        mid();
        chk("rst_src_ready", 32'(src_ready), 32'h0);
        chk("rst_qpn_valid", 32'(qpn_valid), 32'h0);
        chk("rst_qpn_data",  32'(qpn_data),  32'h0);
        chk("rst_grant_src", 32'(grant_src), 32'h0);
        chk("rst_grant_cnt", grant_cnt,      32'h0);

        // Single request
        nxt(); rst = 1'b0; src_valid = 4'b0001;
        mid(); chk("single_src_ready", 32'(src_ready), 32'b0001); push(0);
        nxt(); src_valid = 4'b0000;
        mid();
        chk("single_valid", 32'(qpn_valid), 32'h1);
        chk("single_data",  32'(qpn_data),  32'h000123);
        chk("single_cnt",   grant_cnt,      32'd1);
        chk("single_hold_rdy", 32'(src_ready), 32'h0);
        nxt(); qpn_ready = 1'b1;
        mid(); chk("drain_src_ready", 32'(src_ready), 32'h0);
        nxt(); qpn_ready = 1'b0;
        mid(); chk("drain_valid", 32'(qpn_valid), 32'h0);
        nxt(); qpn_ready = 1'b1;
        mid();
        nxt(); qpn_ready = 1'b0;
        mid();
        chk("idle_ready_valid", 32'(qpn_valid), 32'h0);
        chk("idle_ready_cnt",   grant_cnt,      32'd1);

        // Fairness from a fresh reset: all sources valid
        nxt(); rst = 1'b1;
        mid(); chk("rst2_cnt", grant_cnt, 32'h0);
        nxt(); rst = 1'b0; src_valid = 4'b1111;
        mid(); chk("rr_grant0", 32'(src_ready), 32'b0001); push(0);
        for (int k = 1; k < 6; k++) begin
            nxt(); qpn_ready = 1'b1;
            mid(); chk($sformatf("rr_grant%0d", k), 32'(src_ready), 32'(1 << (k % N))); push(k % N);
        end

        // Back-pressure with all sources still requesting
        for (int c = 0; c < 10; c++) begin
            nxt(); qpn_ready = 1'b0;
            mid();
            chk("bp_src_ready", 32'(src_ready), 32'h0);
            chk("bp_data",      32'(qpn_data),  32'(qv[1]));
            chk("bp_cnt",       grant_cnt,      32'd6);
        end

        // Back-to-back service from source 2
        nxt(); src_valid = 4'b0100; qpn_ready = 1'b1;
        mid();
        chk("b2b_src_ready", 32'(src_ready), 32'b0100);
        chk("b2b_valid_pre", 32'(qpn_valid), 32'h1);
        push(2);
        nxt(); src_valid = 4'b0000; qpn_ready = 1'b0;
        mid();
        chk("b2b_valid",  32'(qpn_valid), 32'h1);
        chk("b2b_data",   32'(qpn_data),  32'(qv[2]));
        chk("b2b_src",    32'(grant_src), 32'd2);
        chk("b2b_cnt",    grant_cnt,      32'd7);

        // Load 0xABCDEF from source 3, then reset while holding it
        nxt(); src_valid = 4'b1000; qpn_ready = 1'b1;
        mid(); chk("s3_src_ready", 32'(src_ready), 32'b1000); push(3);
        nxt(); src_valid = 4'b0000; qpn_ready = 1'b0;
        mid();
        chk("s3_data", 32'(qpn_data), 32'hABCDEF);
        chk("s3_cnt",  grant_cnt,     32'd8);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(qpn_valid), 32'h0);
        chk("async_cnt",   grant_cnt,      32'h0);
        chk("async_data",  32'(qpn_data),  32'h0);
        sb.delete();
        nxt(); rst = 1'b0; src_valid = 4'b1010;
        mid(); chk("post_rst_grant", 32'(src_ready), 32'b0010); push(1);
        nxt(); src_valid = 4'b0000; qpn_ready = 1'b1;
        mid();
        chk("post_rst_valid", 32'(qpn_valid), 32'h1);
        chk("post_rst_data",  32'(qpn_data),  32'(qv[1]));
        nxt(); qpn_ready = 1'b0;
        mid();
        chk("final_valid", 32'(qpn_valid), 32'h0);
        chk("final_cnt",   grant_cnt,      32'd1);

        nxt();
        mid();
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sq_qpn_arbiter.md
SQ_QPN_ARBITER -- requirements
Module: sq_qpn_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, is the number of QPN request sources (legal range 2..8).
REQ-002 Parameter QPN_WIDTH, default 24, is the QPN width in bits.
REQ-003 Port clk  input  1  is the clock; all logic is rising-edge clocked.
REQ-004 Port rst  input  1  is the reset: asynchronous, active-high.
REQ-005 Port src_valid  input  NUM_SRC  has one bit per source; bit i means source i presents a QPN.
REQ-006 Port src_qpn  input  NUM_SRC*QPN_WIDTH  carries source i's QPN in bits [i*QPN_WIDTH +: QPN_WIDTH].
REQ-007 Port src_ready  output  NUM_SRC  is the one-hot (or zero) accept strobe per source.
REQ-008 Port qpn_valid  output  1  means a registered QPN is offered to the SQ context-fetch stage.
REQ-009 Port qpn_data  output  QPN_WIDTH  is the offered QPN.
REQ-010 Port qpn_ready  input  1  means the context-fetch stage has consumed qpn_data (pulsed on fetch-request completion).
REQ-011 Port grant_src  output  3  is the source index of the QPN currently held (debug).
REQ-012 Port grant_cnt  output  32  counts accepted QPNs (statistics).

Function
REQ-013 The FSM shall have exactly two states: IDLE (holding register empty) and HOLD (holding register full).
REQ-014 qpn_valid shall be 1 iff the state is HOLD; qpn_data and grant_src shall be registered and shall stay stable throughout HOLD.
REQ-015 Arbitration shall be round-robin: the search starts at index (last_grant+1) mod NUM_SRC and wraps, and the first source with src_valid=1 wins.
REQ-016 A capture opportunity shall exist in IDLE, and in HOLD in the cycle qpn_ready=1.
REQ-017 On a capture opportunity with any src_valid=1, src_ready[winner] shall be 1 combinationally in that cycle, with all other bits 0.
REQ-018 On that same capture, the holding register shall load src_qpn[winner], last_grant shall load winner, the state shall become or stay HOLD, and grant_cnt shall increment.
REQ-019 Latency: a QPN accepted in cycle N shall appear on qpn_valid/qpn_data in cycle N+1.
REQ-020 qpn_ready=1 in HOLD with no src_valid shall move the state to IDLE and drop qpn_valid in the next cycle.
REQ-021 A qpn_ready=1 in HOLD together with a pending source shall give back-to-back service: no bubble, and new data in the next cycle.
REQ-022 qpn_ready while in IDLE shall be ignored.
REQ-023 src_ready shall be all-zero in HOLD when qpn_ready=0.
REQ-024 A source shall be allowed to drop src_valid before acceptance; arbitration shall use only the current-cycle src_valid.
REQ-025 The QPN shall pass through all QPN_WIDTH bits unmodified; no truncation to QP index shall occur here.
REQ-026 grant_cnt shall wrap from 0xFFFFFFFF to 0 silently.
REQ-027 The FSM shall recover to IDLE from any illegal state encoding.

Reset
REQ-028 Under rst, the state shall be IDLE, qpn_valid 0, qpn_data 0, grant_src 0, src_ready 0, grant_cnt 0, and last_grant NUM_SRC-1, so that source 0 has first priority.
REQ-029 A reset asserted mid-HOLD shall discard the held QPN with no qpn_ready required; the first capture after deassertion shall follow REQ-028 priority.

Verification
REQ-030 Single request: after reset, src_valid=0001 with src_qpn[0]=0x000123 in cycle 1 -> src_ready=0001 in cycle 1; qpn_valid=1 with qpn_data=0x000123 from cycle 2 until qpn_ready.
REQ-031 Fairness: all 4 sources held valid continuously, qpn_ready pulsed each HOLD cycle -> grant order 0,1,2,3,0,1 and grant_cnt=6 after 6 grants.
REQ-032 Back-pressure: qpn_ready held 0 for 10 cycles in HOLD with src_valid=1111 -> qpn_data constant, src_ready=0000 throughout, grant_cnt unchanged.
REQ-033 Back-to-back: qpn_ready=1 in the same cycle that src_valid[2]=1 -> src_ready=0100 in that cycle, and the new QPN appears the next cycle with no qpn_valid gap.
REQ-034 Drain: qpn_ready=1 with src_valid=0000 -> qpn_valid=0 in the next cycle; a later qpn_ready pulse in IDLE causes no state change.
REQ-035 Reset in HOLD (qpn_data=0xABCDEF) -> qpn_valid=0 immediately (asynchronously), grant_cnt=0; a subsequent src_valid=1010 grants source 1 first.
